// File: rtl/modport_counter_pkg.sv
// Shared definitions for the modport_counter block.
//   CNT_W   : default counter width
//   count_t : counter value type at the default width
//   CNT_MAX : all-ones count value at the default width
package modport_counter_pkg;

  localparam int CNT_W = 4;

  typedef logic [CNT_W-1:0] count_t;

  localparam count_t CNT_MAX = '1;

endpackage : modport_counter_pkg

// File: rtl/modport_counter_next.sv
// Combinational next-count logic for modport_counter.
// Ports:
//   count      : current registered count
//   data_in    : parallel load value
//   load       : load request, highest priority
//   up_down    : 1 = step up, 0 = step down (ignored while load is high)
//   count_next : value the register takes at the next rising edge
// Priority: load (saturating at MAX_COUNT), then up step, then down step.
// Steps wrap inside 0..MAX_COUNT; there is no hold case.
module modport_counter_next
  import modport_counter_pkg::*;
#(
  parameter int WIDTH     = CNT_W,
  parameter int MAX_COUNT = 2**WIDTH - 1
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             up_down,
  output logic [WIDTH-1:0] count_next
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

  always_comb begin
    count_next = count;
    if (load) begin
      // Clamp loads above the legal range so count never leaves 0..MAX_COUNT.
      count_next = (data_in > MAX_V) ? MAX_V : data_in;
    end else if (up_down) begin
      count_next = (count == MAX_V) ? '0 : count + 1'b1;
    end else begin
      count_next = (count == '0) ? MAX_V : count - 1'b1;
    end
  end

endmodule : modport_counter_next

// File: rtl/modport_counter.sv
// Loadable up/down counter with wrap-around and saturating load.
// Ports:
//   clock   : rising-edge clock
//   resetn  : asynchronous active-low reset, clears count immediately
//   data_in : parallel load value
//   load    : load data_in at the next rising edge (wins over up_down)
//   up_down : 1 = count up, 0 = count down
//   count   : registered counter value
// No handshake: the counter moves one step (or loads) on every rising edge
// while resetn is high. count comes straight from a flop.
module modport_counter
  import modport_counter_pkg::*;
#(
  parameter int WIDTH     = CNT_W,
  parameter int MAX_COUNT = 2**WIDTH - 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             up_down,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  modport_counter_next #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT)
  ) u_next (
    .count      (count_q),
    .data_in    (data_in),
    .load       (load),
    .up_down    (up_down),
    .count_next (count_d)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule : modport_counter

// File: tb/tb_modport_counter.sv
// Self-checking bench for modport_counter. Two instances share the stimulus:
// the default 4-bit/15 counter and a 4-bit counter with MAX_COUNT=9, which
// exercises the saturating load and the non-power-of-two wrap.
module tb_modport_counter;

  logic       clock;
  logic       resetn;
  logic [3:0] data_in;
  logic       load;
  logic       up_down;
  logic [3:0] count;
  logic [3:0] count9;

  int total = 0;
  int bad   = 0;

  int  model15;
  int  model9;
  bit  cmp_en = 0;

  modport_counter dut (
    .clock   (clock),
    .resetn  (resetn),
    .data_in (data_in),
    .load    (load),
    .up_down (up_down),
    .count   (count)
  );

  modport_counter #(.WIDTH(4), .MAX_COUNT(9)) dut9 (
    .clock   (clock),
    .resetn  (resetn),
    .data_in (data_in),
    .load    (load),
    .up_down (up_down),
    .count   (count9)
  );

  // clock / reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: modulo arithmetic on integers.
  function automatic int model_next(int cur, bit ld, int d, bit ud, int mx);
    if (ld) return (d > mx) ? mx : d;
    if (ud) return (cur + 1) % (mx + 1);
    return (cur + mx) % (mx + 1);
  endfunction

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      model15 <= 0;
      model9  <= 0;
    end else begin
      model15 <= model_next(model15, load, int'(data_in), up_down, 15);
      model9  <= model_next(model9,  load, int'(data_in), up_down, 9);
    end
  end

  // Compare process: every falling edge, both instances against the model.
  always @(negedge clock) begin
    if (cmp_en) begin
      total = total + 1;
      if (int'(count) != model15) begin
        bad = bad + 1;
        $display("FAIL model_cmp15 t=%0t count=%0d expected=%0d", $time, count, model15);
      end
      total = total + 1;
      if (int'(count9) != model9) begin
        bad = bad + 1;
        $display("FAIL model_cmp9 t=%0t count=%0d expected=%0d", $time, count9, model9);
      end
    end
  end

  // Hand-computed literal checks.
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s count=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Driver: called just after a falling edge; applies inputs, passes one
  // rising edge and returns 1ns after the next falling edge.
  task automatic drive(input bit ld, input logic [3:0] d, input bit ud);
    load    = ld;
    data_in = d;
    up_down = ud;
    @(posedge clock);
    @(negedge clock);
    #1;
  endtask

  // Watchdog keeps the run bounded no matter what.
  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn  = 1'b0;
    load    = 1'b1;
    data_in = 4'd9;
    up_down = 1'b0;
    #1;
    check("reset_immediate", count, 4'd0);
    @(negedge clock);
    #1;
    cmp_en = 1;

    // Reset held with load=1/data_in=9: count stays 0.
    drive(1, 4'd9, 0); check("reset_hold0", count, 4'd0);
    drive(1, 4'd9, 0); check("reset_hold1", count, 4'd0);
    resetn = 1'b1;
    drive(0, 4'd0, 1); check("reset_release", count, 4'd1);

    // Load then count up.
    drive(1, 4'd7, 0); check("load7", count, 4'd7);
    drive(0, 4'd0, 1); check("up8", count, 4'd8);
    drive(0, 4'd0, 1); check("up9", count, 4'd9);
    drive(0, 4'd0, 1); check("up10", count, 4'd10);
    check("max9_wrap_at_10", count9, 4'd0);

    // Up wrap (14 saturates to 9 in the MAX_COUNT=9 instance).
    drive(1, 4'd14, 1); check("load14", count, 4'd14);
    check("max9_sat_load", count9, 4'd9);
    drive(0, 4'd0, 1); check("upwrap15", count, 4'd15);
    check("max9_upwrap0", count9, 4'd0);
    drive(0, 4'd0, 1); check("upwrap0", count, 4'd0);
    drive(0, 4'd0, 1); check("upwrap1", count, 4'd1);

    // Down wrap.
    drive(1, 4'd1, 1); check("load1", count, 4'd1);
    drive(0, 4'd0, 0); check("down0", count, 4'd0);
    drive(0, 4'd0, 0); check("downwrap15", count, 4'd15);
    check("max9_downwrap9", count9, 4'd9);
    drive(0, 4'd0, 0); check("downwrap14", count, 4'd14);

    // Load priority over down step.
    drive(1, 4'd5, 1); check("load5", count, 4'd5);
    drive(1, 4'd3, 0); check("load_prio3", count, 4'd3);
    drive(0, 4'd0, 0); check("after_load2", count, 4'd2);

    // Full-scale load then down; saturating load of 15 into MAX_COUNT=9.
    drive(1, 4'd15, 0); check("load15", count, 4'd15);
    check("max9_sat15", count9, 4'd9);
    drive(0, 4'd0, 0); check("down14", count, 4'd14);

    // Asynchronous reset mid-count at 6, during a pending load.
    drive(1, 4'd5, 1); check("load5b", count, 4'd5);
    drive(0, 4'd0, 1); check("up6", count, 4'd6);
    load    = 1'b1;
    data_in = 4'd12;
    resetn  = 1'b0;
    #1;
    check("async_reset", count, 4'd0);
    check("async_reset9", count9, 4'd0);
    #1;
    resetn = 1'b1;
    drive(0, 4'd0, 1); check("resume1", count, 4'd1);
    drive(0, 4'd0, 1); check("resume2", count, 4'd2);

    // A burst of directed steps, checked only by the model.
    for (int i = 0; i < 20; i++) begin
      drive(i % 7 == 3, 4'(i * 5), (i % 3) != 0);
    end

    cmp_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_modport_counter
